// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the LEGv8 multicycle datapath. Sequences fetch, decode,
// address/ALU execute, memory access and write-back for LDUR, STUR, CBZ and
// the R-type ADD/SUB/AND/ORR group. Unknown opcodes raise a one-cycle
// `illegal` pulse in DECODE and the FSM returns to FETCH without retiring.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   op             in  11   instruction[31:21] from the instruction register
//   mem_ready      in   1   shared memory completes the current access
//   pc_write       out  1   unconditional PC load
//   pc_write_cond  out  1   PC load when ALU zero (CBZ)
//   pc_src         out  1   0: ALU result, 1: ALUOut
//   iord           out  1   0: address = PC, 1: ALUOut
//   ir_write       out  1   load instruction register
//   mem_read       out  1   memory read strobe
//   mem_write      out  1   memory write strobe
//   reg2loc        out  1   1: read register 2 = Rt, 0: Rm
//   reg_write      out  1   register file write
//   mem_to_reg     out  1   write-back data: 1 MDR, 0 ALUOut
//   alu_src_a      out  1   0: PC, 1: register A
//   alu_src_b      out  2   00 B, 01 const 4, 10 signext, 11 signext<<2
//   alu_op         out  2   00 add, 01 pass B, 10 funct-decoded
//   illegal        out  1   one-cycle pulse on an unrecognised opcode
//   instr_done     out  1   one-cycle pulse when an instruction retires
//   retired        out 32   retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic        iord,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg2loc,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic        instr_done,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t      r_state;
    logic [31:0] r_retired;

    // Opcode classes; only meaningful while op is stable (DECODE..write-back).
    logic w_is_ldur;
    logic w_is_stur;
    logic w_is_cbz;
    logic w_is_rtype;
    logic w_is_illegal;

    assign w_is_ldur    = (op == 11'b11111000010);
    assign w_is_stur    = (op == 11'b11111000000);
    assign w_is_cbz     = (op[10:3] == 8'b10110100);
    assign w_is_rtype   = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                          (op == 11'b10001010000) || (op == 11'b10101010000);
    assign w_is_illegal = !(w_is_ldur || w_is_stur || w_is_cbz || w_is_rtype);

    // Retirement happens in the last cycle of every legal instruction; a store
    // only retires in the cycle its memory write completes.
    logic w_instr_done;
    assign w_instr_done = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                          (r_state == S_BRANCH) ||
                          ((r_state == S_MEMWRITE) && mem_ready);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            if (w_instr_done) begin
                r_retired <= r_retired + 32'd1;
            end
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_ldur || w_is_stur) r_state <= S_MEMADR;
                    else if (w_is_rtype)        r_state <= S_EXEC_R;
                    else if (w_is_cbz)          r_state <= S_BRANCH;
                    else                        r_state <= S_FETCH;
                end
                S_MEMADR: begin
                    if (w_is_ldur)      r_state <= S_MEMREAD;
                    else if (w_is_stur) r_state <= S_MEMWRITE;
                    else                r_state <= S_FETCH;
                end
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXEC_R:   r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path through the
    // block leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg2loc       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // Reset already parks the state in FETCH; gating here keeps the
                // fetch strobes quiet while reset is held even if memory is ready.
                if (mem_ready && reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;              // branch target into ALUOut
                reg2loc   = w_is_stur || w_is_cbz;
                illegal   = w_is_illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg2loc   = w_is_stur;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                reg2loc    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                reg2loc       = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                instr_done    = 1'b1;
            end
            default: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
            end
        endcase
    end

    assign retired = r_retired;

endmodule
